// File: rtl/dense_seq_pkg.sv
// Shared types, widths and elaboration helpers for the dense-layer
// MAC sequencer and its multiplier.
package dense_seq_pkg;

    localparam int X_W = 12;
    localparam int W_W = 9;
    localparam int P_W = X_W + W_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_EMIT    = 2'd3
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Vector width able to index v items; never narrower than one bit.
    function automatic int bits(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

    function automatic bit acc_w_ok(
        input int acc_w,
        input int p_w,
        input int n_in
    );
        return acc_w >= p_w + clog2(n_in);
    endfunction

endpackage

// File: rtl/dense_mac_sequencer_mul.sv
// Combinational signed x unsigned multiplier; kept separate so a
// DSP-mapped implementation can be dropped in.
module mul_12s_9ns_21 #(
    parameter int X_W = dense_seq_pkg::X_W,
    parameter int W_W = dense_seq_pkg::W_W,
    parameter int P_W = dense_seq_pkg::P_W
) (
    input  logic signed [X_W-1:0] a,
    input  logic        [W_W-1:0] b,
    output logic signed [P_W-1:0] p
);

    logic signed [P_W-1:0] ax;
    logic signed [P_W-1:0] bx;

    assign ax = P_W'(a);
    assign bx = P_W'($signed({1'b0, b}));
    assign p  = ax * bx;

endmodule

// File: rtl/dense_mac_sequencer.sv
// Collects one input vector, then runs N_OUT dot products through a
// single shared multiplier, emitting each accumulator on valid/ready.
module dense_mac_sequencer #(
    parameter int N_IN   = 16,
    parameter int N_OUT  = 8,
    parameter int X_W    = dense_seq_pkg::X_W,
    parameter int W_W    = dense_seq_pkg::W_W,
    parameter int P_W    = dense_seq_pkg::P_W,
    parameter int ACC_W  = 25,
    parameter int ADDR_W = 7
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic signed [X_W-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [ADDR_W-1:0]       w_addr,
    output logic                    w_rd_en,
    input  logic [W_W-1:0]          w_data,
    output logic signed [ACC_W-1:0] out_data,
    output logic [dense_seq_pkg::bits(N_OUT)-1:0] out_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    import dense_seq_pkg::*;

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] LOAD    = ST_LOAD;
    localparam logic [1:0] COMPUTE = ST_COMPUTE;
    localparam logic [1:0] EMIT    = ST_EMIT;

    localparam int CNT_W = clog2(N_IN + 1);
    localparam int IDX_W = bits(N_IN);
    localparam int J_W   = bits(N_OUT);

    localparam logic [CNT_W-1:0]  I_LAST = CNT_W'(N_IN - 1);
    localparam logic [CNT_W-1:0]  I_END  = CNT_W'(N_IN);
    localparam logic [CNT_W-1:0]  I_ONE  = CNT_W'(1);
    localparam logic [J_W-1:0]    J_LAST = J_W'(N_OUT - 1);
    localparam logic [J_W-1:0]    J_ONE  = J_W'(1);
    localparam logic [ADDR_W-1:0] A_STEP = ADDR_W'(N_IN);

    if (!acc_w_ok(ACC_W, P_W, N_IN)) begin : g_acc_chk
        $error("dense_mac_sequencer: ACC_W too narrow");
    end
    if (P_W != X_W + W_W) begin : g_pw_chk
        $error("dense_mac_sequencer: P_W must be X_W+W_W");
    end
    if (ADDR_W < bits(N_IN * N_OUT)) begin : g_aw_chk
        $error("dense_mac_sequencer: ADDR_W too narrow");
    end

    logic [1:0]              state;
    logic [CNT_W-1:0]        i;
    logic [J_W-1:0]          j;
    logic [ADDR_W-1:0]       wbase;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [X_W-1:0]   op_x;
    logic signed [P_W-1:0]   prod;
    logic signed [X_W-1:0]   xbuf [N_IN];
    logic                    accept;
    logic                    issue;

    assign in_ready  = (state == IDLE) || (state == LOAD);
    assign accept    = in_ready && in_valid;
    assign issue     = (state == COMPUTE) && (i < I_END);
    assign w_rd_en   = issue;
    assign w_addr    = issue ? wbase + ADDR_W'(i) : '0;
    assign out_valid = (state == EMIT);
    assign out_data  = acc;
    assign out_idx   = j;
    assign busy      = (state != IDLE);

    mul_12s_9ns_21 #(
        .X_W (X_W),
        .W_W (W_W),
        .P_W (P_W)
    ) u_mul (
        .a (op_x),
        .b (w_data),
        .p (prod)
    );

    // First product of a neuron overwrites the previous sum.
    assign prod_ext = ACC_W'(prod);
    assign acc_base = (i == I_ONE) ? '0 : acc;

    always_ff @(posedge ap_clk) begin
        if (accept) xbuf[i[IDX_W-1:0]] <= in_data;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            wbase <= '0;
            acc   <= '0;
            op_x  <= '0;
        end else begin
            unique case (state)
                IDLE, LOAD: begin
                    if (accept) begin
                        if (i == I_LAST) begin
                            i     <= '0;
                            j     <= '0;
                            wbase <= '0;
                            state <= COMPUTE;
                        end else begin
                            i     <= i + I_ONE;
                            state <= LOAD;
                        end
                    end
                end
                COMPUTE: begin
                    if (issue) op_x <= xbuf[i[IDX_W-1:0]];
                    if (i != '0) acc <= acc_base + prod_ext;
                    if (i == I_END) begin
                        i     <= '0;
                        state <= EMIT;
                    end else begin
                        i <= i + I_ONE;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (j == J_LAST) begin
                            j     <= '0;
                            wbase <= '0;
                            state <= IDLE;
                        end else begin
                            j     <= j + J_ONE;
                            wbase <= wbase + A_STEP;
                            state <= COMPUTE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
